// File: rtl/assume_example_pkg.sv
// Shared types and constants for the assertion-stimulus generator.
package assume_example_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ANTE,
        WAIT,
        CONS,
        GAP,
        DONE
    } state_t;

    localparam int unsigned DELAY_MAX         = 7;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    // Widened to 5 bits so 15 + 3 cannot wrap.
    function automatic logic [4:0] gap_len(input logic [3:0] gap, input logic [1:0] rnd);
        return {1'b0, gap} + {3'b000, rnd};
    endfunction

endpackage

// File: rtl/assume_example_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), stepping once per adv.
module assume_example_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (adv) begin
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        end
    end

endmodule

// File: rtl/assume_example_stim_rtl.sv
// Generates a/b handshake stimulus runs with optional fault injection and
// the verdict an a-implies-b checker is expected to produce.
module assume_example_stim_rtl
    import assume_example_pkg::*;
#(
    parameter int unsigned DELAY     = 1,
    parameter int unsigned CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_txn,
    input  logic [3:0]       gap,
    input  logic             inject_fail,
    input  logic [CNT_W-1:0] fail_idx,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] txn_count,
    output logic             exp_pass,
    output logic             exp_fail
);

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] txn_q, txn_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] fidx_q, fidx_d;
    logic [3:0]       gap_q, gap_d;
    logic             inj_q, inj_d;
    logic             a_q, b_q, busy_q, done_q, pass_q, fail_q;
    logic             lfsr_adv;
    logic [15:0]      lfsr_q;
    logic [4:0]       gap_cycles;
    logic             fault_d;
    logic             lfsr_unused;

    assume_example_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .adv  (lfsr_adv),
        .q    (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q[15:2];
    assign gap_cycles  = gap_len(gap_q, lfsr_q[1:0]);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        txn_d    = txn_q;
        num_d    = num_q;
        fidx_d   = fidx_q;
        gap_d    = gap_q;
        inj_d    = inj_q;
        lfsr_adv = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    num_d   = num_txn;
                    fidx_d  = fail_idx;
                    gap_d   = gap;
                    inj_d   = inject_fail;
                    txn_d   = '0;
                    state_d = (num_txn == '0) ? DONE : ANTE;
                end
            end
            ANTE: begin
                if (DELAY == 1) begin
                    state_d = CONS;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 5'(DELAY - 1);
                end
            end
            WAIT: begin
                if (cnt_q <= 5'd1) state_d = CONS;
                else               cnt_d   = cnt_q - 5'd1;
            end
            CONS: begin
                lfsr_adv = 1'b1;
                txn_d    = txn_q + CNT_W'(1);
                if (txn_d == num_q) begin
                    state_d = DONE;
                end else if (gap_cycles == 5'd0) begin
                    state_d = ANTE;
                end else begin
                    state_d = GAP;
                    cnt_d   = gap_cycles;
                end
            end
            GAP: begin
                if (cnt_q <= 5'd1) state_d = ANTE;
                else               cnt_d   = cnt_q - 5'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Fault match uses the count held throughout CONS (it only moves on CONS exit).
    assign fault_d = inj_d && (txn_d == fidx_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            txn_q   <= '0;
            num_q   <= '0;
            fidx_q  <= '0;
            gap_q   <= '0;
            inj_q   <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            txn_q   <= txn_d;
            num_q   <= num_d;
            fidx_q  <= fidx_d;
            gap_q   <= gap_d;
            inj_q   <= inj_d;
            a_q     <= (state_d == ANTE);
            b_q     <= (state_d == CONS) && !fault_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            pass_q  <= (state_d == CONS) && !fault_d;
            fail_q  <= (state_d == CONS) && fault_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign txn_count = txn_q;
    assign exp_pass  = pass_q;
    assign exp_fail  = fail_q;

endmodule
